// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
//   Shared definitions for the serial pattern generator: FSM state encoding
//   and the default 4-bit frame used by the matching sequence detectors.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg
//   W-bit loadable left-shift register with serial MSB output. Zeros enter
//   at the LSB on every shift. Load has priority over shift.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (register cleared)
//   load   in   load din on the next edge
//   shift  in   shift left by one on the next edge
//   din    in   W-bit parallel load value
//   ser_o  out  current MSB (a flop output)
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         ser_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {data_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_o = data_q[W-1];

endmodule

// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator
//   Serial bit-pattern transmitter. On an accepted start it captures a
//   PAT_W-bit pattern and a frame count, then sends the pattern MSB-first,
//   one bit per clock, for the requested number of frames with GAP idle
//   cycles between frames.
//   Optional build macro SEQ_GEN_PARITY_EN appends one even-parity bit
//   (XOR of the captured pattern) after bit 0 of every frame.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   single-cycle request, sampled only in IDLE
//   pattern    in   PAT_W-bit frame, MSB sent first
//   frames     in   RPT_W-bit frame count (0 treated as 1)
//   out        out  serial data (registered)
//   out_valid  out  high on every pattern/parity bit cycle
//   busy       out  high from the cycle after start until done
//   done       out  one-cycle pulse after the final frame
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// SEND   | shifting frame bits out (plus parity bit when enabled)
// GAP    | idle-zero spacing between frames, busy held high
// FIN    | done pulse for one cycle, start ignored
module seq_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int RPT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [RPT_W-1:0] frames,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [RPT_W-1:0]   frm_q, frm_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               sr_load;
  logic               sr_shift;
  logic [PAT_W-1:0]   sr_din;
  logic               sr_ser;
  logic               frame_end;

  // The shift register doubles as the output flop: whatever sits in its MSB
  // is the line value. Idle/gap/done cycles load zeros so out stays low.
  seq_shift_reg #(
    .W (PAT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .ser_o (sr_ser)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    frm_d     = frm_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = '0;
    frame_end = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          frm_d     = (frames == '0) ? RPT_W'(1) : frames;
          bit_cnt_d = BIT_LAST;
          sr_load   = 1'b1;
          sr_din    = pattern;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        busy_d = 1'b1;
        if (bit_cnt_q != '0) begin
          sr_shift  = 1'b1;
          valid_d   = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          // Bit 0 is on the line: insert the parity cycle once, then end.
          if (!par_q) begin
            par_d             = 1'b1;
            sr_load           = 1'b1;
            sr_din[PAT_W-1]   = ^pat_q;
            valid_d           = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
`else
          frame_end = 1'b1;
`endif
        end

        if (frame_end) begin
          sr_load = 1'b1;
          if (frm_q > RPT_W'(1)) begin
            frm_d = frm_q - RPT_W'(1);
            if (GAP > 0) begin
              gap_cnt_d = GAP_LAST;
              state_d   = S_GAP;
            end else begin
              // Back-to-back: next frame's MSB follows bit 0 directly.
              sr_din    = pat_q;
              bit_cnt_d = BIT_LAST;
              valid_d   = 1'b1;
            end
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == '0) begin
          sr_load   = 1'b1;
          sr_din    = pat_q;
          bit_cnt_d = BIT_LAST;
          valid_d   = 1'b1;
          state_d   = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      frm_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      frm_q     <= frm_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign out       = sr_ser;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
module tb_seq_pattern_generator;
  import seq_gen_pkg::*;

`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] pat_a = '0, frm_a = '0, pat_b = '0, frm_b = '0;
  logic       out_a, ov_a, busy_a, done_a;
  logic       out_b, ov_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  // expected per-cycle tuple {out, out_valid, busy, done}
  logic [3:0] exp_q[$];

  typedef struct {
    bit         sel;       // 0: GAP=2 instance, 1: GAP=0 instance
    logic [3:0] pat;
    logic [3:0] frm;
    int         exp_done;  // cycle of done pulse, no-parity build
    int         exp_vcnt;  // out_valid cycles, no-parity build
    int         exp_hits;  // 1101 detector hits, -1 = not checked
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  seq_pattern_generator #(.PAT_W(4), .RPT_W(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern(pat_a), .frames(frm_a),
    .out(out_a), .out_valid(ov_a), .busy(busy_a), .done(done_a)
  );

  seq_pattern_generator #(.PAT_W(4), .RPT_W(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern(pat_b), .frames(frm_b),
    .out(out_b), .out_valid(ov_b), .busy(busy_b), .done(done_b)
  );

  // Reference: frames of MSB-first bits (+parity), gap zeros between frames,
  // then a single done cycle.
  function automatic void build_model(input logic [3:0] p, input logic [3:0] f, input int g);
    int nf;
    nf = (f == 4'd0) ? 1 : int'(f);
    exp_q.delete();
    for (int fr = 0; fr < nf; fr++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (PAR != 0) exp_q.push_back({^p, 3'b110});
      if (fr < nf - 1)
        for (int i = 0; i < g; i++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  function automatic logic [3:0] snap(input bit sel);
    return sel ? {out_b, ov_b, busy_b, done_b} : {out_a, ov_a, busy_a, done_a};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b (out,valid,busy,done)", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [3:0] p, input logic [3:0] f);
    if (sel) begin
      start_b = s; pat_b = p; frm_b = f;
    end else begin
      start_a = s; pat_a = p; frm_a = f;
    end
  endtask

  // Caller is #1 after a rising edge with the DUT idle.
  task automatic run_xfer(input bit sel, input logic [3:0] p, input logic [3:0] f,
                          input bit noisy, output int done_at, output int vcnt, output int hits);
    logic [3:0] act;
    logic [3:0] win;
    int nb;
    build_model(p, f, sel ? 0 : 2);
    done_at = 0; vcnt = 0; hits = 0; win = '0; nb = 0;
    drive(sel, 1'b1, p, f);
    @(posedge clk); #1;
    drive(sel, 1'b0, p, f);
    for (int k = 1; k <= exp_q.size(); k++) begin
      act = snap(sel);
      chk("stream", k, act, exp_q[k-1]);
      if (act[0] && done_at == 0) done_at = k;
      if (act[2]) vcnt++;
      win = {win[2:0], act[3]};
      nb++;
      if (nb >= 4 && win == DEFAULT_PATTERN) begin
        hits++;
        nb = 0;
      end
      if (noisy) drive(sel, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 4'($urandom), 4'($urandom));
    chk("post_idle", exp_q.size() + 1, snap(sel), 4'b0000);
  endtask

  initial begin
    int done_at, vcnt, hits, feff, seen;

    tbl[0] = '{1'b0, 4'b1101, 4'd1,  5,  4,  1};
    tbl[1] = '{1'b0, 4'b1101, 4'd3,  17, 12, 3};
    tbl[2] = '{1'b1, 4'b1101, 4'd0,  5,  4,  1};
    tbl[3] = '{1'b1, 4'b1101, 4'd2,  9,  8,  2};
    tbl[4] = '{1'b0, 4'b1001, 4'd2,  11, 8,  -1};
    tbl[5] = '{1'b0, 4'b0000, 4'd15, 89, 60, 0};
    tbl[6] = '{1'b1, 4'b1111, 4'd15, 61, 60, -1};
    tbl[7] = '{1'b0, 4'b0110, 4'd0,  5,  4,  -1};

    // Reset held with start toggling.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("reset_a", i, snap(0), 4'b0000);
      chk("reset_b", i, snap(1), 4'b0000);
      start_a = 1'($urandom_range(0, 1)); pat_a = 4'($urandom); frm_a = 4'($urandom);
      start_b = 1'($urandom_range(0, 1)); pat_b = 4'($urandom); frm_b = 4'($urandom);
    end
    start_a = 1'b0; start_b = 1'b0;
    #($urandom_range(1, 3));
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("idle_after_reset_a", i, snap(0), 4'b0000);
      chk("idle_after_reset_b", i, snap(1), 4'b0000);
    end

    // Table-driven transfers.
    for (int t = 0; t < 8; t++) begin
      feff = (tbl[t].frm == 4'd0) ? 1 : int'(tbl[t].frm);
      run_xfer(tbl[t].sel, tbl[t].pat, tbl[t].frm, t[0], done_at, vcnt, hits);
      chk_int($sformatf("tbl%0d_done_cycle", t), done_at, tbl[t].exp_done + PAR * feff);
      chk_int($sformatf("tbl%0d_valid_cycles", t), vcnt, tbl[t].exp_vcnt + PAR * feff);
      if (tbl[t].exp_hits >= 0)
        chk_int($sformatf("tbl%0d_detector_hits", t), hits, tbl[t].exp_hits);
    end

    // Start in FIN ignored, start in the first IDLE cycle accepted.
    drive(0, 1'b1, 4'b1101, 4'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'b1101, 4'd1);
    for (int i = 0; i < 4 + PAR; i++) begin
      @(posedge clk); #1;
    end
    chk("restart_done", 5 + PAR, snap(0), 4'b0001);
    drive(0, 1'b1, 4'b1001, 4'd1);
    @(posedge clk); #1;
    chk("restart_fin_ignored", 6 + PAR, snap(0), 4'b0000);
    @(posedge clk); #1;
    chk("restart_first_bit", 7 + PAR, snap(0), 4'b1110);
    drive(0, 1'b0, 4'b0000, 4'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a) begin
        seen = 1;
        break;
      end
    end
    chk_int("restart_done_seen", seen, 1);
    @(posedge clk); #1;

    // Reset after the 2nd bit abandons the frame.
    drive(0, 1'b1, 4'b1011, 4'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'b0100, 4'd1);
    chk("midrst_bit1", 1, snap(0), 4'b1110);
    @(posedge clk); #1;
    chk("midrst_bit2", 2, snap(0), 4'b0110);
    #3 rst = 1'b0;
    #1 chk("midrst_async", 2, snap(0), 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_hold", i, snap(0), 4'b0000);
      start_a = 1'($urandom_range(0, 1));
    end
    start_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", 0, snap(0), 4'b0000);
    run_xfer(0, 4'b0110, 4'd1, 1'b0, done_at, vcnt, hits);
    chk_int("midrst_new_done_cycle", done_at, 5 + PAR);

    // Randomised transfers against the reference.
    for (int r = 0; r < 25; r++) begin
      logic [3:0] p, f;
      bit s;
      s = 1'($urandom_range(0, 1));
      p = 4'($urandom);
      f = 4'($urandom_range(0, 6));
      feff = (f == 4'd0) ? 1 : int'(f);
      run_xfer(s, p, f, 1'b1, done_at, vcnt, hits);
      chk_int($sformatf("rand%0d_valid_cycles", r), vcnt, feff * (4 + PAR));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_generator.md
Name: seq_pattern_generator

Overview:
- Serial bit-pattern transmitter and the source-side counterpart of the sequence detectors; default frame 1101.
- Captures a PAT_W-bit pattern and a frame count on start, then shifts the pattern out MSB-first, one bit per clk.
- Sends the requested number of frames, with GAP idle-zero cycles between frames so a non-overlapping detector sees clean, separated frames.
- Feeds detector DUTs in benches and on-chip self-test paths.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- RPT_W, 4, frame-count field width.
- GAP, 2, idle cycles (out=0, out_valid=0) between consecutive frames; 0 = back-to-back.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-low; all state cleared while rst=0.
- start  in  1  single-cycle request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send, captured on accepted start; bit PAT_W-1 is sent first.
- frames  in  RPT_W  number of frames, captured on accepted start; 0 is treated as 1.
- out  out  1  serial data, registered.
- out_valid  out  1  high on every cycle carrying a pattern bit (or parity bit).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out=0, out_valid=0, busy=0, done=0; shift register and counters cleared.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - Outputs are 0.
  - start=1 at a rising edge: capture pattern and frames (0->1), load bit counter = PAT_W-1, go to SEND.
  - On that same edge, drive out=pattern[PAT_W-1], out_valid=1, busy=1.
  - Latency: first bit is visible in the cycle immediately after the start edge.
- SEND:
  - Each edge shifts the register left and drives the next bit; bit counter decrements.
  - After bit 0 is driven, the next edge does one of the following:
    - frames remaining >1 and GAP>0: go to GAP, decrement frames.
    - frames remaining >1 and GAP=0: reload the captured pattern and keep sending, so bit PAT_W-1 of the next frame directly follows bit 0; decrement frames.
    - last frame: go to FIN.
  - A frame occupies exactly PAT_W cycles with out_valid=1.
- GAP:
  - out=0, out_valid=0, busy=1 for exactly GAP cycles.
  - Then reload the captured pattern and go to SEND with the first bit driven on the exiting edge.
- FIN:
  - done=1, busy=0, out=0, out_valid=0 for one cycle, then IDLE.
  - A start seen in FIN is ignored.
  - A start in the first IDLE cycle is accepted, so the minimum spacing between done and the next first bit is 2 cycles.
- Inputs:
  - start while busy or in FIN is ignored.
  - pattern and frames changing mid-transmission have no effect; only the captured copies are used.
- Counters:
  - Bit counter width is $clog2(PAT_W).
  - The frame counter is RPT_W bits.
  - Neither counter wraps, because both terminate at their final value.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse; any partial frame is abandoned.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined: after bit 0 of each frame, one extra cycle drives out = even parity (XOR of the captured pattern) with out_valid=1. A frame is then PAT_W+1 cycles; gap and done timing shift by one cycle per frame.
- Undefined: no parity cycle, no parity logic.

Decomposition:
- Package seq_gen_pkg: FSM state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2, FIN=2'd3) and the default pattern constant 4'b1101.
- One sub-module, seq_shift_reg: a PAT_W-bit loadable left-shift register with serial MSB output; the FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=0 with start=1 toggling -> out=0, out_valid=0, busy=0, done=0 throughout; release at an arbitrary time -> still IDLE.
- Single frame: pattern=4'b1101, frames=1, GAP=2 -> out = 1,1,0,1 on the 4 cycles after start with out_valid=1; done pulses on the 5th cycle; busy high on cycles 1-4.
- Three frames, GAP=2: pattern=1101, frames=3 -> out sequence 1101 00 1101 00 1101, out_valid low only on the gap cycles; a non-overlapping 1101 detector fires exactly 3 times; done on cycle 17.
- GAP=0 back-to-back with frames=0: frames=0 -> exactly one frame sent. Then frames=2 -> 11011101 continuous, with out_valid high 8 cycles.
- Ignore and reset: start pulses mid-frame and new pattern values are ignored; asserting rst=0 after the 2nd bit -> outputs 0 asynchronously and no done pulse. A new start after release sends the full new pattern.
- With SEQ_GEN_PARITY_EN: pattern=1101 -> out=1,1,0,1,1 (parity=1). Pattern=1001 -> parity bit 0. Frame length is 5 cycles.
